// File: rtl/pipe_defs.sv
// rtl/pipe_defs.sv - shared pipeline bundle layout, ALU op indices and divider states
package pipe_defs;

  localparam int ID_EX_W   = 196;
  localparam int EX_MEM_W  = 111;
  localparam int DIV_STEPS = 32;

  // ID->EX bundle: bit position (LSB for multi-bit fields)
  localparam int IE_VALID   = 195;
  localparam int IE_PC      = 163;
  localparam int IE_INST    = 131;
  localparam int IE_SRC1    = 99;
  localparam int IE_SRC2    = 67;
  localparam int IE_ALU_OP  = 55;
  localparam int IE_LD      = 50;
  localparam int IE_ST_B    = 49;
  localparam int IE_ST_H    = 48;
  localparam int IE_ST_W    = 47;
  localparam int IE_MEM_WE  = 46;
  localparam int IE_RES_MEM = 45;
  localparam int IE_GR_WE   = 44;
  localparam int IE_RKD     = 12;
  localparam int IE_DEST    = 7;
  localparam int IE_MUL     = 6;
  localparam int IE_MULH    = 5;
  localparam int IE_MULHU   = 4;
  localparam int IE_DIV     = 3;
  localparam int IE_MOD     = 2;
  localparam int IE_DIVU    = 1;
  localparam int IE_MODU    = 0;

  localparam int ALU_ADD   = 0;
  localparam int ALU_SUB   = 1;
  localparam int ALU_SLT   = 2;
  localparam int ALU_SLTU  = 3;
  localparam int ALU_AND   = 4;
  localparam int ALU_NOR   = 5;
  localparam int ALU_OR    = 6;
  localparam int ALU_XOR   = 7;
  localparam int ALU_SLL   = 8;
  localparam int ALU_SRL   = 9;
  localparam int ALU_SRA   = 10;
  localparam int ALU_LU12I = 11;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_iter.sv
// rtl/div_iter.sv - unsigned radix-2 restoring divider, one quotient bit per cycle
module div_iter
  import pipe_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        ack,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        idle,
  output logic        done,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  div_state_t  state;
  logic [4:0]  cnt;
  logic [31:0] q, r, d;
  logic [32:0] shifted;
  logic [33:0] trial;

  // Partial remainder can reach 33 bits after the shift, so the trial is 34 bits wide.
  assign shifted = {r, q[31]};
  assign trial   = {1'b0, shifted} - {2'b00, d};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DIV_IDLE;
      cnt   <= 5'd0;
      q     <= 32'd0;
      r     <= 32'd0;
      d     <= 32'd0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            state <= DIV_BUSY;
            cnt   <= 5'd0;
            q     <= dividend;
            r     <= 32'd0;
            d     <= divisor;
          end
        end
        DIV_BUSY: begin
          if (trial[33]) begin
            r <= shifted[31:0];
            q <= {q[30:0], 1'b0};
          end else begin
            r <= trial[31:0];
            q <= {q[30:0], 1'b1};
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'(DIV_STEPS - 1)) state <= DIV_DONE;
        end
        DIV_DONE: begin
          if (ack) state <= DIV_IDLE;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

  assign idle = (state == DIV_IDLE);
  assign done = (state == DIV_DONE);
  assign quot = q;
  assign rem  = r;

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - LoongArch execute stage: ALU, multiply, iterative divide, data-SRAM request
module ex_stage
  import pipe_defs::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_EX_W-1:0]  ID_to_EX_bus,
  input  logic                MEM_allowin,
  output logic                EX_allowin,
  output logic                front_from_EX_valid,
  output logic [4:0]          front_from_EX_addr,
  output logic [31:0]         front_from_EX_data,
  output logic                data_sram_en,
  output logic [3:0]          data_sram_we,
  output logic [31:0]         data_sram_addr,
  output logic [31:0]         data_sram_wdata,
  output logic [EX_MEM_W-1:0] EX_to_MEM_reg
);

  logic        valid;
  logic [31:0] pc, inst, src1, src2, rkd;
  logic [11:0] alu_op;
  logic [4:0]  ld_flags, dest, shamt;
  logic        st_b, st_h, st_w, mem_we, res_from_mem, gr_we;
  logic        op_mul, op_mulh, op_mulhu, op_div, op_mod, op_divu, op_modu;

  assign valid        = ID_to_EX_bus[IE_VALID];
  assign pc           = ID_to_EX_bus[IE_PC +: 32];
  assign inst         = ID_to_EX_bus[IE_INST +: 32];
  assign src1         = ID_to_EX_bus[IE_SRC1 +: 32];
  assign src2         = ID_to_EX_bus[IE_SRC2 +: 32];
  assign alu_op       = ID_to_EX_bus[IE_ALU_OP +: 12];
  assign ld_flags     = ID_to_EX_bus[IE_LD +: 5];
  assign st_b         = ID_to_EX_bus[IE_ST_B];
  assign st_h         = ID_to_EX_bus[IE_ST_H];
  assign st_w         = ID_to_EX_bus[IE_ST_W];
  assign mem_we       = ID_to_EX_bus[IE_MEM_WE];
  assign res_from_mem = ID_to_EX_bus[IE_RES_MEM];
  assign gr_we        = ID_to_EX_bus[IE_GR_WE];
  assign rkd          = ID_to_EX_bus[IE_RKD +: 32];
  assign dest         = ID_to_EX_bus[IE_DEST +: 5];
  assign op_mul       = ID_to_EX_bus[IE_MUL];
  assign op_mulh      = ID_to_EX_bus[IE_MULH];
  assign op_mulhu     = ID_to_EX_bus[IE_MULHU];
  assign op_div       = ID_to_EX_bus[IE_DIV];
  assign op_mod       = ID_to_EX_bus[IE_MOD];
  assign op_divu      = ID_to_EX_bus[IE_DIVU];
  assign op_modu      = ID_to_EX_bus[IE_MODU];
  assign shamt        = src2[4:0];

  logic [31:0] add_res, sub_res, sra_res, alu_res;
  assign add_res = src1 + src2;
  assign sub_res = src1 - src2;
  assign sra_res = $unsigned($signed(src1) >>> shamt);

  assign alu_res = ({32{alu_op[ALU_ADD]}}   & add_res)
                 | ({32{alu_op[ALU_SUB]}}   & sub_res)
                 | ({32{alu_op[ALU_SLT]}}   & {31'd0, $signed(src1) < $signed(src2)})
                 | ({32{alu_op[ALU_SLTU]}}  & {31'd0, src1 < src2})
                 | ({32{alu_op[ALU_AND]}}   & (src1 & src2))
                 | ({32{alu_op[ALU_NOR]}}   & ~(src1 | src2))
                 | ({32{alu_op[ALU_OR]}}    & (src1 | src2))
                 | ({32{alu_op[ALU_XOR]}}   & (src1 ^ src2))
                 | ({32{alu_op[ALU_SLL]}}   & (src1 << shamt))
                 | ({32{alu_op[ALU_SRL]}}   & (src1 >> shamt))
                 | ({32{alu_op[ALU_SRA]}}   & sra_res)
                 | ({32{alu_op[ALU_LU12I]}} & src2);

  // Sign-extending only for mulh keeps one 64-bit product valid for all three mul flavours.
  logic [63:0] mul_a, mul_b, mul_prod;
  logic [31:0] mul_res;
  logic        is_mul;
  assign mul_a    = {{32{op_mulh & src1[31]}}, src1};
  assign mul_b    = {{32{op_mulh & src2[31]}}, src2};
  assign mul_prod = mul_a * mul_b;
  assign is_mul   = op_mul | op_mulh | op_mulhu;
  assign mul_res  = (op_mulh | op_mulhu) ? mul_prod[63:32] : mul_prod[31:0];

  logic        is_div_op, is_div, signed_div, s1, s2;
  logic        div_idle, div_done, q_neg, r_neg;
  logic [31:0] abs1, abs2, div_quot, div_rem, quot_fix, rem_fix, div_res;
  assign is_div_op  = op_div | op_mod | op_divu | op_modu;
  assign is_div     = valid & is_div_op;
  assign signed_div = op_div | op_mod;
  assign s1         = signed_div & src1[31];
  assign s2         = signed_div & src2[31];
  assign abs1       = s1 ? (32'd0 - src1) : src1;
  assign abs2       = s2 ? (32'd0 - src2) : src2;

  div_iter u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (is_div),
    .ack      (MEM_allowin),
    .dividend (abs1),
    .divisor  (abs2),
    .idle     (div_idle),
    .done     (div_done),
    .quot     (div_quot),
    .rem      (div_rem)
  );

  // Divide-by-zero keeps the all-ones quotient, so its sign flip is suppressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (is_div & div_idle) begin
      q_neg <= (s1 ^ s2) & (|src2);
      r_neg <= s1;
    end
  end

  assign quot_fix = q_neg ? (32'd0 - div_quot) : div_quot;
  assign rem_fix  = r_neg ? (32'd0 - div_rem) : div_rem;
  assign div_res  = (op_div | op_divu) ? quot_fix : rem_fix;

  logic        readygo;
  logic [31:0] ex_result;
  assign readygo   = ~is_div | div_done;
  assign ex_result = is_div_op ? div_res : is_mul ? mul_res : alu_res;

  assign EX_allowin          = ~valid | (readygo & MEM_allowin);
  assign front_from_EX_valid = valid & gr_we & ~res_from_mem & (|dest);
  assign front_from_EX_addr  = dest;
  assign front_from_EX_data  = ex_result;

  assign data_sram_en   = valid & (mem_we | res_from_mem) & readygo & MEM_allowin;
  assign data_sram_addr = add_res;

  always_comb begin
    data_sram_we    = 4'b0000;
    data_sram_wdata = rkd;
    if (st_w) begin
      data_sram_we = 4'b1111;
    end else if (st_h) begin
      data_sram_we    = 4'b0011 << {add_res[1], 1'b0};
      data_sram_wdata = {2{rkd[15:0]}};
    end else if (st_b) begin
      data_sram_we    = 4'b0001 << add_res[1:0];
      data_sram_wdata = {4{rkd[7:0]}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      EX_to_MEM_reg <= '0;
    end else if (MEM_allowin) begin
      EX_to_MEM_reg <= readygo ? {valid, pc, inst, ex_result, ld_flags, res_from_mem,
                                  gr_we, dest, add_res[1:0]} : '0;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - randomized and directed self-checking bench for ex_stage
module tb_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, inst, src1, src2;
    logic [11:0] alu_op;
    logic        ld_b, ld_bu, ld_h, ld_hu, ld_w, st_b, st_h, st_w, mem_we, res_from_mem, gr_we;
    logic [31:0] rkd;
    logic [4:0]  dest;
    logic        mul, mulh, mulhu, div, mod, divu, modu;
  } id_ex_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, inst, result;
    logic        ld_b, ld_bu, ld_h, ld_hu, ld_w, res_from_mem, gr_we;
    logic [4:0]  dest;
    logic [1:0]  addr;
  } ex_mem_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  id_ex_t       bus = '0;
  logic         mem_allowin = 1'b1;
  logic         ex_allowin, f_valid, sram_en;
  logic [4:0]   f_addr;
  logic [31:0]  f_data, sram_addr, sram_wdata;
  logic [3:0]   sram_we;
  logic [110:0] ex_mem;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk                 (clk),
    .rst                 (rst),
    .ID_to_EX_bus        (bus),
    .MEM_allowin         (mem_allowin),
    .EX_allowin          (ex_allowin),
    .front_from_EX_valid (f_valid),
    .front_from_EX_addr  (f_addr),
    .front_from_EX_data  (f_data),
    .data_sram_en        (sram_en),
    .data_sram_we        (sram_we),
    .data_sram_addr      (sram_addr),
    .data_sram_wdata     (sram_wdata),
    .EX_to_MEM_reg       (ex_mem)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_alu(id_ex_t b);
    logic [31:0] r;
    int sh;
    r  = '0;
    sh = int'(b.src2[4:0]);
    for (int i = 0; i < 12; i++) begin
      if (b.alu_op[i]) begin
        case (i)
          0:  r = b.src1 + b.src2;
          1:  r = b.src1 - b.src2;
          2:  r = ($signed(b.src1) < $signed(b.src2)) ? 32'd1 : 32'd0;
          3:  r = (b.src1 < b.src2) ? 32'd1 : 32'd0;
          4:  r = b.src1 & b.src2;
          5:  r = ~(b.src1 | b.src2);
          6:  r = b.src1 | b.src2;
          7:  r = b.src1 ^ b.src2;
          8:  r = b.src1 << sh;
          9:  r = b.src1 >> sh;
          10: r = $signed(b.src1) >>> sh;
          default: r = b.src2;
        endcase
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_mul(id_ex_t b);
    int          a, d;
    longint      sp;
    logic [63:0] up;
    a  = b.src1;
    d  = b.src2;
    sp = longint'(a) * longint'(d);
    up = {32'd0, b.src1} * {32'd0, b.src2};
    if (b.mulhu) return up[63:32];
    if (b.mulh)  return sp[63:32];
    return sp[31:0];
  endfunction

  function automatic logic [31:0] ref_div(id_ex_t b);
    logic [31:0] q, r;
    int          a, d;
    a = b.src1;
    d = b.src2;
    if (b.src2 == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = b.src1;
    end else if (b.divu | b.modu) begin
      q = b.src1 / b.src2;
      r = b.src1 % b.src2;
    end else if (b.src1 == 32'h8000_0000 && d == -1) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = a / d;
      r = a % d;
    end
    return (b.div | b.divu) ? q : r;
  endfunction

  function automatic logic [31:0] ref_result(id_ex_t b);
    if (b.div | b.mod | b.divu | b.modu) return ref_div(b);
    if (b.mul | b.mulh | b.mulhu)        return ref_mul(b);
    return ref_alu(b);
  endfunction

  // A divide leaves EX 33 cycles after it arrives; anything else is ready at once.
  int          elapsed = 0;
  ex_mem_t     model_em = '0;
  id_ex_t      cb;
  logic        c_div, c_ready, c_allow, c_en;
  logic [31:0] c_addr, c_wdata, c_res;
  logic [3:0]  c_we;

  always @(negedge clk) begin
    if (chk_en) begin
      cb      = bus;
      c_div   = cb.valid & (cb.div | cb.mod | cb.divu | cb.modu);
      c_ready = !c_div || (elapsed >= 33);
      c_allow = !cb.valid || (c_ready && mem_allowin);
      c_en    = cb.valid & (cb.mem_we | cb.res_from_mem) & c_ready & mem_allowin;
      c_addr  = cb.src1 + cb.src2;
      c_res   = ref_result(cb);
      c_we    = 4'b0000;
      c_wdata = cb.rkd;
      if (cb.st_w) c_we = 4'hF;
      else if (cb.st_h) begin
        c_we    = c_addr[1] ? 4'b1100 : 4'b0011;
        c_wdata = {cb.rkd[15:0], cb.rkd[15:0]};
      end else if (cb.st_b) begin
        case (c_addr[1:0])
          2'd0: c_we = 4'b0001;
          2'd1: c_we = 4'b0010;
          2'd2: c_we = 4'b0100;
          default: c_we = 4'b1000;
        endcase
        c_wdata = {4{cb.rkd[7:0]}};
      end

      check("allowin", 32'(ex_allowin), 32'(c_allow));
      check("front_valid", 32'(f_valid),
            32'(cb.valid & cb.gr_we & ~cb.res_from_mem & (cb.dest != 5'd0)));
      check("front_addr", 32'(f_addr), 32'(cb.dest));
      if (c_allow && cb.valid) check("front_data", f_data, c_res);
      check("sram_en", 32'(sram_en), 32'(c_en));
      if (c_en) begin
        check("sram_addr", sram_addr, c_addr);
        check("sram_we", 32'(sram_we), 32'(c_we));
        if (cb.mem_we) check("sram_wdata", sram_wdata, c_wdata);
      end
      checks++;
      if (ex_mem !== model_em) begin
        errors++;
        $display("FAIL ex_to_mem: got %h expected %h", ex_mem, model_em);
      end

      if (rst) begin
        model_em = '0;
        elapsed  = 0;
      end else begin
        if (mem_allowin) begin
          model_em = '0;
          if (c_ready) begin
            model_em.valid        = cb.valid;
            model_em.pc           = cb.pc;
            model_em.inst         = cb.inst;
            model_em.result       = c_res;
            model_em.ld_b         = cb.ld_b;
            model_em.ld_bu        = cb.ld_bu;
            model_em.ld_h         = cb.ld_h;
            model_em.ld_hu        = cb.ld_hu;
            model_em.ld_w         = cb.ld_w;
            model_em.res_from_mem = cb.res_from_mem;
            model_em.gr_we        = cb.gr_we;
            model_em.dest         = cb.dest;
            model_em.addr         = c_addr[1:0];
          end
        end
        elapsed = c_allow ? 0 : elapsed + 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 40));
      5: return 32'd0 - 32'($urandom_range(1, 40));
      default: return $urandom;
    endcase
  endfunction

  function automatic id_ex_t base(input logic [31:0] a, input logic [31:0] b);
    id_ex_t x;
    x       = '0;
    x.valid = 1'b1;
    x.pc    = 32'h1C00_0100;
    x.inst  = 32'h0010_1234;
    x.src1  = a;
    x.src2  = b;
    x.dest  = 5'd5;
    x.gr_we = 1'b1;
    return x;
  endfunction

  function automatic id_ex_t rand_inst();
    id_ex_t b;
    int     k;
    b = base(rnd32(), rnd32());
    b.pc   = $urandom;
    b.inst = $urandom;
    b.rkd  = $urandom;
    b.dest = 5'($urandom_range(0, 31));
    k = $urandom_range(0, 9);
    if (k == 0) b = '0;
    else if (k <= 3) b.alu_op[$urandom_range(0, 11)] = 1'b1;
    else if (k == 4) begin
      case ($urandom_range(0, 2))
        0: b.mul = 1'b1;
        1: b.mulh = 1'b1;
        default: b.mulhu = 1'b1;
      endcase
    end else if (k <= 6) begin
      case ($urandom_range(0, 3))
        0: b.div = 1'b1;
        1: b.mod = 1'b1;
        2: b.divu = 1'b1;
        default: b.modu = 1'b1;
      endcase
    end else if (k == 7) begin
      b.alu_op[0]    = 1'b1;
      b.res_from_mem = 1'b1;
      case ($urandom_range(0, 4))
        0: b.ld_b = 1'b1;
        1: b.ld_bu = 1'b1;
        2: b.ld_h = 1'b1;
        3: b.ld_hu = 1'b1;
        default: b.ld_w = 1'b1;
      endcase
    end else if (k == 8) begin
      b.alu_op[0] = 1'b1;
      b.mem_we    = 1'b1;
      b.gr_we     = 1'b0;
      case ($urandom_range(0, 2))
        0: b.st_b = 1'b1;
        1: b.st_h = 1'b1;
        default: b.st_w = 1'b1;
      endcase
    end else begin
      b.gr_we = 1'($urandom_range(0, 1));
      b.alu_op[$urandom_range(0, 11)] = 1'b1;
    end
    return b;
  endfunction

  task automatic send(input id_ex_t b, input bit rand_mem);
    int n;
    bit acc;
    n   = 0;
    bus = b;
    forever begin
      @(negedge clk);
      acc = ex_allowin;
      step();
      if (rand_mem) mem_allowin = ($urandom_range(0, 3) != 0);
      if (acc) break;
      n++;
      if (n > 400) begin
        check("send_timeout", 32'(n), 32'd0);
        break;
      end
    end
  endtask

  // Returns at the first negedge with EX_allowin high; n = low cycles seen before it.
  task automatic wait_allow(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (ex_allowin) break;
      n++;
      if (n > 200) begin
        check("allow_timeout", 32'(n), 32'd0);
        break;
      end
    end
  endtask

  // ---------------- test sequence ----------------
  id_ex_t  t;
  ex_mem_t em;
  int      n, en_cnt;

  initial begin
    repeat (2) step();
    rst    = 1'b0;
    chk_en = 1'b1;

    @(negedge clk);
    check("reset_exmem_valid", 32'(ex_mem[110]), 32'd0);
    check("reset_allowin", 32'(ex_allowin), 32'd1);
    check("reset_sram_en", 32'(sram_en), 32'd0);
    step();

    t = base(32'd5, 32'd7);
    t.alu_op[0] = 1'b1;
    bus = t;
    @(negedge clk);
    check("t1_model", ref_result(t), 32'd12);
    check("t1_front_valid", 32'(f_valid), 32'd1);
    check("t1_front_data", f_data, 32'd12);
    step();
    bus = '0;
    @(negedge clk);
    em = ex_mem_t'(ex_mem);
    check("t1_exmem_result", em.result, 32'd12);
    check("t1_exmem_valid", 32'(em.valid), 32'd1);
    step();

    t = base(32'hFFFF_FFF9, 32'd2);
    t.div = 1'b1;
    bus = t;
    check("t2_model_div", ref_result(t), 32'hFFFF_FFFD);
    wait_allow(n);
    check("t2_div_stall", 32'(n), 32'd33);
    check("t2_div_quot", f_data, 32'hFFFF_FFFD);
    step();
    t.div = 1'b0;
    t.mod = 1'b1;
    bus = t;
    check("t2_model_mod", ref_result(t), 32'hFFFF_FFFF);
    wait_allow(n);
    check("t2_mod_stall", 32'(n), 32'd33);
    check("t2_mod_rem", f_data, 32'hFFFF_FFFF);
    step();

    t = base(32'h0000_1234, 32'd0);
    t.divu = 1'b1;
    bus = t;
    wait_allow(n);
    check("t3_divu_zero", f_data, 32'hFFFF_FFFF);
    step();
    t.divu = 1'b0;
    t.modu = 1'b1;
    bus = t;
    wait_allow(n);
    check("t3_modu_zero", f_data, 32'h0000_1234);
    step();

    t = base(32'h0000_1000, 32'd3);
    t.alu_op[0] = 1'b1;
    t.mem_we    = 1'b1;
    t.gr_we     = 1'b0;
    t.st_b      = 1'b1;
    t.rkd       = 32'h0000_00AB;
    bus = t;
    mem_allowin = 1'b0;
    en_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      check("t4_stalled_en", 32'(sram_en), 32'd0);
      en_cnt += int'(sram_en);
      step();
    end
    mem_allowin = 1'b1;
    @(negedge clk);
    check("t4_en", 32'(sram_en), 32'd1);
    check("t4_we", 32'(sram_we), 32'h8);
    check("t4_wdata", sram_wdata, 32'hABAB_ABAB);
    en_cnt += int'(sram_en);
    step();
    bus = '0;
    @(negedge clk);
    en_cnt += int'(sram_en);
    check("t4_en_once", 32'(en_cnt), 32'd1);
    step();

    t = base(32'h8000_0000, 32'd2);
    t.mulh = 1'b1;
    bus = t;
    @(negedge clk);
    check("t5_model_mulh", ref_result(t), 32'hFFFF_FFFF);
    check("t5_mulh", f_data, 32'hFFFF_FFFF);
    step();
    t.mulh  = 1'b0;
    t.mulhu = 1'b1;
    bus = t;
    @(negedge clk);
    check("t5_mulhu", f_data, 32'h0000_0001);
    step();

    t = base(32'd100, 32'd7);
    t.div = 1'b1;
    bus = t;
    repeat (10) @(negedge clk);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ex_mem !== 111'd0) begin
      errors++;
      $display("FAIL t6_exmem_cleared: got %h expected 0", ex_mem);
    end
    check("t6_restart_stall", 32'(ex_allowin), 32'd0);
    wait_allow(n);
    check("t6_restart_len", 32'(n + 1), 32'd33);
    check("t6_quot", f_data, 32'd14);
    step();
    bus = '0;

    for (int i = 0; i < 250; i++) send(rand_inst(), 1'b1);
    mem_allowin = 1'b1;
    send('0, 1'b0);
    send('0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
